vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_if.sv | 47 ++++
 rtl/vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU, fetch-port, RAM and statistics signals of the VRAM arbiter
interface vram_arbiter_if;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_strobe;
    logic        cpu_write;
    logic [7:0]  cpu_rddata;

    logic        f0_req,     f1_req,     f2_req;
    logic [14:0] f0_addr,    f1_addr,    f2_addr;
    logic        f0_ack,     f1_ack,     f2_ack;
    logic        f0_rdvalid, f1_rdvalid, f2_rdvalid;
    logic [31:0] f0_rddata,  f1_rddata,  f2_rddata;

    logic [14:0] ram_addr;
    logic [31:0] ram_wrdata;
    logic [3:0]  ram_wrbytesel;
    logic        ram_write;
    logic [31:0] ram_rddata;

    logic        stat_clear;
    logic [15:0] stat_cpu_cnt;
    logic [15:0] stat_stall_cnt;
    logic [7:0]  stat_max_wait;

    modport slave (
        input  cpu_addr, cpu_wrdata, cpu_strobe, cpu_write,
        input  f0_req, f1_req, f2_req, f0_addr, f1_addr, f2_addr,
        input  ram_rddata, stat_clear,
        output cpu_rddata,
        output f0_ack, f1_ack, f2_ack, f0_rdvalid, f1_rdvalid, f2_rdvalid,
        output f0_rddata, f1_rddata, f2_rddata,
        output ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
        output stat_cpu_cnt, stat_stall_cnt, stat_max_wait
    );

    modport master (
        output cpu_addr, cpu_wrdata, cpu_strobe, cpu_write,
        output f0_req, f1_req, f2_req, f0_addr, f1_addr, f2_addr,
        output ram_rddata, stat_clear,
        input  cpu_rddata,
        input  f0_ack, f1_ack, f2_ack, f0_rdvalid, f1_rdvalid, f2_rdvalid,
        input  f0_rddata, f1_rddata, f2_rddata,
        input  ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
        input  stat_cpu_cnt, stat_stall_cnt, stat_max_wait
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: CPU absolute priority, round-robin fetch ports
// Optional statistics counters enabled by defining VRAM_ARB_STATS_EN.
module vram_arbiter (
    input  logic           bm_clk,
    input  logic           bm_reset,
    vram_arbiter_if.slave  bus
);
    logic [2:0]  req;
    logic [2:0]  grant;
    logic        found;
    logic [1:0]  ord [3];
    logic [1:0]  rr_q, rr_d;
    logic [14:0] addr_q, ram_addr_d;
    logic [2:0]  rdvalid_q;
    logic        rd_pend_q;
    logic [1:0]  sel_q;
    logic [7:0]  cap_q, cpu_rddata_d;

    assign req = {bus.f2_req, bus.f1_req, bus.f0_req};

    always_comb begin
        case (rr_q)
            2'd1:    begin ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd0; end
            2'd2:    begin ord[0] = 2'd2; ord[1] = 2'd0; ord[2] = 2'd1; end
            default: begin ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; end
        endcase
    end

    // The CPU strobe blocks every fetch grant; otherwise first requester from rr wins.
    always_comb begin
        grant = 3'b000;
        rr_d  = rr_q;
        found = 1'b0;
        if (!bus.cpu_strobe) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && req[ord[i]]) begin
                    found          = 1'b1;
                    grant[ord[i]]  = 1'b1;
                    rr_d           = (ord[i] == 2'd2) ? 2'd0 : ord[i] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        ram_addr_d        = addr_q;
        bus.ram_write     = 1'b0;
        bus.ram_wrbytesel = 4'b0000;
        bus.ram_wrdata    = {4{bus.cpu_wrdata}};
        if (bus.cpu_strobe) begin
            ram_addr_d = bus.cpu_addr[16:2];
            if (bus.cpu_write) begin
                bus.ram_write     = 1'b1;
                bus.ram_wrbytesel = 4'b0001 << bus.cpu_addr[1:0];
            end
        end else if (grant[0]) begin
            ram_addr_d = bus.f0_addr;
        end else if (grant[1]) begin
            ram_addr_d = bus.f1_addr;
        end else if (grant[2]) begin
            ram_addr_d = bus.f2_addr;
        end
    end

    assign bus.ram_addr = ram_addr_d;

    // Read byte is muxed straight from RAM on the return cycle and held afterwards.
    assign cpu_rddata_d   = rd_pend_q ? bus.ram_rddata[{sel_q, 3'b000} +: 8] : cap_q;
    assign bus.cpu_rddata = cpu_rddata_d;

    always_ff @(posedge bm_clk) begin
        if (bm_reset) begin
            rr_q      <= 2'd0;
            addr_q    <= 15'd0;
            rdvalid_q <= 3'b000;
            rd_pend_q <= 1'b0;
            sel_q     <= 2'd0;
            cap_q     <= 8'd0;
        end else begin
            rr_q      <= rr_d;
            addr_q    <= ram_addr_d;
            rdvalid_q <= grant;
            rd_pend_q <= bus.cpu_strobe && !bus.cpu_write;
            sel_q     <= bus.cpu_addr[1:0];
            cap_q     <= cpu_rddata_d;
        end
    end

    assign bus.f0_ack     = grant[0];
    assign bus.f1_ack     = grant[1];
    assign bus.f2_ack     = grant[2];
    assign bus.f0_rdvalid = rdvalid_q[0];
    assign bus.f1_rdvalid = rdvalid_q[1];
    assign bus.f2_rdvalid = rdvalid_q[2];
    assign bus.f0_rddata  = bus.ram_rddata;
    assign bus.f1_rddata  = bus.ram_rddata;
    assign bus.f2_rddata  = bus.ram_rddata;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] cpu_cnt_q, stall_cnt_q;
    logic [7:0]  max_wait_q, max_wait_d;
    logic [7:0]  wait_q [3];
    logic [7:0]  wait_d [3];

    // Per-port run length of unacknowledged request cycles, saturating at 255.
    always_comb begin
        max_wait_d = max_wait_q;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !grant[i]) begin
                wait_d[i] = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
            end else begin
                wait_d[i] = 8'd0;
            end
            if (wait_d[i] > max_wait_d) begin
                max_wait_d = wait_d[i];
            end
        end
    end

    always_ff @(posedge bm_clk) begin
        if (bm_reset || bus.stat_clear) begin
            cpu_cnt_q   <= 16'd0;
            stall_cnt_q <= 16'd0;
            max_wait_q  <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                wait_q[i] <= 8'd0;
            end
        end else begin
            if (bus.cpu_strobe && cpu_cnt_q != 16'hFFFF) begin
                cpu_cnt_q <= cpu_cnt_q + 16'd1;
            end
            if ((|req) && !(|grant) && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            max_wait_q <= max_wait_d;
            for (int i = 0; i < 3; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.stat_cpu_cnt   = cpu_cnt_q;
    assign bus.stat_stall_cnt = stall_cnt_q;
    assign bus.stat_max_wait  = max_wait_q;
`else
    logic unused_stat_clear;
    assign unused_stat_clear  = bus.stat_clear;
    assign bus.stat_cpu_cnt   = 16'd0;
    assign bus.stat_stall_cnt = 16'd0;
    assign bus.stat_max_wait  = 8'd0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter with a behavioural VRAM
module tb_vram_arbiter;
    logic bm_clk = 1'b0;
    logic bm_reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   w [3];
    int   maxw;
    logic [2:0] exp_ack;

    always #5 bm_clk = ~bm_clk;

    vram_arbiter_if bus();

    vram_arbiter dut (
        .bm_clk   (bm_clk),
        .bm_reset (bm_reset),
        .bus      (bus)
    );

    // Word i of the RAM starts as 0xC0DE0000 | i (reloaded on every reset).
    logic [31:0] mem [32768];
    always @(posedge bm_clk) begin
        if (bm_reset) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
        end else if (bus.ram_write) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_wrbytesel[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wrdata[8*b +: 8];
        end
        bus.ram_rddata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge bm_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_strobe = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_addr = 17'd0;  bus.cpu_wrdata = 8'd0;
        bus.f0_req = 1'b0; bus.f1_req = 1'b0; bus.f2_req = 1'b0;
        bus.f0_addr = 15'd0; bus.f1_addr = 15'd0; bus.f2_addr = 15'd0;
        bus.stat_clear = 1'b0;
    endtask

    function automatic logic [2:0] acks();
        return {bus.f2_ack, bus.f1_ack, bus.f0_ack};
    endfunction

    function automatic logic [2:0] rdvs();
        return {bus.f2_rdvalid, bus.f1_rdvalid, bus.f0_rdvalid};
    endfunction

    initial begin
        idle_inputs();
        bm_reset = 1'b1;
        repeat (3) @(posedge bm_clk);
        #1 bm_reset = 1'b0;
        @(negedge bm_clk);
        check("rst_ack", 32'(acks()), 32'h0);
        check("rst_rdvalid", 32'(rdvs()), 32'h0);
        check("rst_ram_write", 32'(bus.ram_write), 32'h0);
        check("rst_wrbytesel", 32'(bus.ram_wrbytesel), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check("rst_cpu_rddata", 32'(bus.cpu_rddata), 32'h0);
        check("rst_stats", {bus.stat_cpu_cnt, bus.stat_stall_cnt} | 32'(bus.stat_max_wait), 32'h0);

        // CPU byte write then read-back
        next_cycle();
        bus.cpu_strobe = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 17'h00006; bus.cpu_wrdata = 8'hA5;
        @(negedge bm_clk);
        check("wr_ram_write", 32'(bus.ram_write), 32'h1);
        check("wr_bytesel", 32'(bus.ram_wrbytesel), 32'h4);
        check("wr_data", bus.ram_wrdata, 32'hA5A5A5A5);
        check("wr_addr", 32'(bus.ram_addr), 32'h1);
        next_cycle();
        bus.cpu_write = 1'b0;
        @(negedge bm_clk);
        check("rd_ram_write", 32'(bus.ram_write), 32'h0);
        check("rd_bytesel", 32'(bus.ram_wrbytesel), 32'h0);
        next_cycle();
        bus.cpu_strobe = 1'b0;
        @(negedge bm_clk);
        check("rd_data", 32'(bus.cpu_rddata), 32'hA5);
        next_cycle();
        @(negedge bm_clk);
        check("rd_hold", 32'(bus.cpu_rddata), 32'hA5);
        check("idle_addr_hold", 32'(bus.ram_addr), 32'h1);

        // All fetch ports requesting: strict rotation 0,1,2,0,1,2
        next_cycle();
        bus.f0_req = 1'b1; bus.f1_req = 1'b1; bus.f2_req = 1'b1;
        bus.f0_addr = 15'h10; bus.f1_addr = 15'h20; bus.f2_addr = 15'h30;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) next_cycle();
            @(negedge bm_clk);
            check($sformatf("rot_ack%0d", t), 32'(acks()), 32'(3'b001 << (t % 3)));
            if (t > 0) begin
                check($sformatf("rot_rdv%0d", t), 32'(rdvs()), 32'(3'b001 << ((t - 1) % 3)));
                check($sformatf("rot_data%0d", t), bus.f0_rddata, 32'hC0DE0000 | 32'(16 * ((t - 1) % 3 + 1)));
            end
        end
        next_cycle();
        bus.f0_req = 1'b0; bus.f1_req = 1'b0; bus.f2_req = 1'b0;
        @(negedge bm_clk);
        check("rot_last_rdv", 32'(rdvs()), 32'h4);
        check("rot_last_data", bus.f2_rddata, 32'hC0DE0030);
        check("rot_no_ack", 32'(acks()), 32'h0);

        // CPU read every other cycle, all ports requesting
        for (int k = 0; k < 3; k++) w[k] = 0;
        maxw = 0;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            bus.f0_req = 1'b1; bus.f1_req = 1'b1; bus.f2_req = 1'b1;
            bus.cpu_strobe = (c % 2 == 0); bus.cpu_write = 1'b0; bus.cpu_addr = 17'h00100;
            @(negedge bm_clk);
            if (c % 2 == 0) begin
                check($sformatf("cpu_cyc_ack%0d", c), 32'(acks()), 32'h0);
                check($sformatf("cpu_cyc_addr%0d", c), 32'(bus.ram_addr), 32'h40);
            end else begin
                check($sformatf("alt_ack%0d", c), 32'(acks()), 32'(3'b001 << ((c / 2) % 3)));
                check($sformatf("alt_rddata%0d", c), 32'(bus.cpu_rddata), 32'h40);
            end
            exp_ack = acks();
            for (int k = 0; k < 3; k++) begin
                w[k] = exp_ack[k] ? 0 : w[k] + 1;
                if (w[k] > maxw) maxw = w[k];
            end
        end
        check("alt_max_wait", 32'(maxw), 32'd5);
        next_cycle();
        idle_inputs();

        // CPU and f1 collide with rr=1
        next_cycle();
        bus.f0_req = 1'b1; bus.f0_addr = 15'h11;
        @(negedge bm_clk);
        check("pre_f0_ack", 32'(acks()), 32'h1);
        next_cycle();
        bus.f0_req = 1'b0;
        bus.cpu_strobe = 1'b1; bus.cpu_addr = 17'h00008;
        bus.f1_req = 1'b1; bus.f1_addr = 15'h21;
        @(negedge bm_clk);
        check("coll_ack", 32'(acks()), 32'h0);
        check("coll_addr", 32'(bus.ram_addr), 32'h2);
        next_cycle();
        bus.cpu_strobe = 1'b0;
        @(negedge bm_clk);
        check("coll_f1_ack", 32'(acks()), 32'h2);
        check("coll_f1_addr", 32'(bus.ram_addr), 32'h21);
        check("coll_cpu_data", 32'(bus.cpu_rddata), 32'h02);
        next_cycle();
        bus.f0_req = 1'b1; bus.f2_req = 1'b1;
        @(negedge bm_clk);
        check("rr_is_2", 32'(acks()), 32'h4);
        next_cycle();
        idle_inputs();

        // Reset during an f2 grant
        next_cycle();
        bus.f0_req = 1'b1;
        @(negedge bm_clk);
        check("pre_rst_f0", 32'(acks()), 32'h1);
        next_cycle();
        bus.f0_req = 1'b0; bus.f2_req = 1'b1; bus.f2_addr = 15'h32; bm_reset = 1'b1;
        @(negedge bm_clk);
        check("rst_cyc_f2_ack", 32'(acks()), 32'h4);
        next_cycle();
        bm_reset = 1'b0; bus.f2_req = 1'b0;
        @(negedge bm_clk);
        check("post_rst_rdv", 32'(rdvs()), 32'h0);
        check("post_rst_write", 32'(bus.ram_write), 32'h0);
        check("post_rst_addr", 32'(bus.ram_addr), 32'h0);
        check("post_rst_cpu", 32'(bus.cpu_rddata), 32'h0);
        next_cycle();
        bus.f0_req = 1'b1;
        @(negedge bm_clk);
        check("rr1_f0", 32'(acks()), 32'h1);
        next_cycle();
        bus.f0_req = 1'b0; bm_reset = 1'b1;
        next_cycle();
        bm_reset = 1'b0; bus.f0_req = 1'b1; bus.f2_req = 1'b1;
        @(negedge bm_clk);
        check("rr_reset_to_0", 32'(acks()), 32'h1);
        next_cycle();
        idle_inputs();

`ifdef VRAM_ARB_STATS_EN
        next_cycle();
        bus.stat_clear = 1'b1;
        next_cycle();
        bus.stat_clear = 1'b0;
        @(negedge bm_clk);
        check("st_clear0", {bus.stat_cpu_cnt, bus.stat_stall_cnt} | 32'(bus.stat_max_wait), 32'h0);
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            bus.f0_req = 1'b1; bus.f0_addr = 15'h5; bus.cpu_strobe = 1'b1; bus.cpu_addr = 17'h0;
            @(negedge bm_clk);
            check($sformatf("st_hold_ack%0d", c), 32'(acks()), 32'h0);
        end
        next_cycle();
        bus.cpu_strobe = 1'b0;
        @(negedge bm_clk);
        check("st_f0_ack", 32'(acks()), 32'h1);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            bus.f0_req = 1'b0; bus.cpu_strobe = 1'b1;
            next_cycle();
            bus.cpu_strobe = 1'b0;
        end
        @(negedge bm_clk);
        check("st_cpu_cnt", 32'(bus.stat_cpu_cnt), 32'd10);
        check("st_max_wait", 32'(bus.stat_max_wait), 32'd7);
        check("st_stall_cnt", 32'(bus.stat_stall_cnt), 32'd7);
        next_cycle();
        bus.stat_clear = 1'b1;
        next_cycle();
        bus.stat_clear = 1'b0;
        @(negedge bm_clk);
        check("st_clear1", {bus.stat_cpu_cnt, bus.stat_stall_cnt} | 32'(bus.stat_max_wait), 32'h0);
`else
        @(negedge bm_clk);
        check("st_off_cpu", 32'(bus.stat_cpu_cnt), 32'h0);
        check("st_off_stall", 32'(bus.stat_stall_cnt), 32'h0);
        check("st_off_wait", 32'(bus.stat_max_wait), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
